// File: rtl/conv_encoder_tx.sv
// Rate-1/2, K=3 convolutional encoder, generators (7,5) octal.
// One coded symbol per accepted bit, plus two zero tail symbols per frame.
module conv_encoder_tx #(
  parameter int unsigned FRAME_LEN = 16
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic       i_valid,
  input  logic       i_bit,
  output logic       o_ready,
  input  logic       i_ready,
  output logic       o_valid,
  output logic [1:0] o_data,
  output logic       o_sof,
  output logic       o_eof,
  output logic       o_busy
);

  localparam int unsigned CW = $clog2(FRAME_LEN + 1);

  typedef enum logic [1:0] {
    IDLE,
    DATA,
    TAIL
  } state_t;

  state_t        state, state_nxt;
  logic          s1, s0;
  logic [CW-1:0] cnt, cnt_nxt;
  logic          slot_free;
  logic          gen;
  logic          u;
  logic          clr;
  logic          sof_nxt;
  logic          eof_nxt;

  always_comb begin
    slot_free = !o_valid || i_ready;
    state_nxt = state;
    cnt_nxt   = cnt;
    o_ready   = 1'b0;
    gen       = 1'b0;
    u         = 1'b0;
    clr       = 1'b0;
    sof_nxt   = 1'b0;
    eof_nxt   = 1'b0;
    case (state)
      IDLE: begin
        if (i_start) begin
          clr       = 1'b1;
          cnt_nxt   = '0;
          state_nxt = DATA;
        end
      end
      DATA: begin
        o_ready = slot_free;
        if (i_valid && slot_free) begin
          gen     = 1'b1;
          u       = i_bit;
          sof_nxt = (cnt == '0);
          if (cnt == CW'(FRAME_LEN - 1)) begin
            cnt_nxt   = '0;
            state_nxt = TAIL;
          end else begin
            cnt_nxt = cnt + 1'b1;
          end
        end
      end
      TAIL: begin
        // Tail symbols flush the register with zeros; the second one ends the frame.
        if (slot_free) begin
          gen     = 1'b1;
          cnt_nxt = cnt + 1'b1;
          if (cnt == CW'(1)) begin
            eof_nxt   = 1'b1;
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign o_busy = (state != IDLE);

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1      <= 1'b0;
      s0      <= 1'b0;
      cnt     <= '0;
      o_valid <= 1'b0;
      o_data  <= '0;
      o_sof   <= 1'b0;
      o_eof   <= 1'b0;
    end else begin
      cnt <= cnt_nxt;
      if (clr) begin
        s1 <= 1'b0;
        s0 <= 1'b0;
      end else if (gen) begin
        s1 <= u;
        s0 <= s1;
      end
      if (gen) begin
        o_data  <= {u ^ s1 ^ s0, u ^ s0};
        o_valid <= 1'b1;
        o_sof   <= sof_nxt;
        o_eof   <= eof_nxt;
      end else if (o_valid && i_ready) begin
        o_valid <= 1'b0;
        o_sof   <= 1'b0;
        o_eof   <= 1'b0;
      end
    end
  end

endmodule

// File: doc/conv_encoder_tx.md
# conv_encoder_tx

Rate-1/2, constraint-length-3 convolutional encoder with generators (7,5) octal, forming the transmit end of the Viterbi decoding chain. It accepts one information bit per handshake, emits one 2-bit coded symbol per bit, and zero-terminates each frame with two tail symbols so the decoder's trellis returns to state 0. The output symbol format matches the 2-bit `i_data` symbol consumed by the decoder.

## Interface
- FRAME_LEN, 16: information bits per frame; must be ≥ 1.
- i_clk  in  1  clock; all state updates on the rising edge.
- i_rst  in  1  reset, asynchronous, active-high.
- i_start  in  1  one-cycle frame start request; honoured only in IDLE.
- i_valid  in  1  `i_bit` is valid.
- i_bit  in  1  information bit.
- o_ready  out  1  encoder accepts `i_bit` this cycle.
- i_ready  in  1  downstream accepts `o_data` this cycle.
- o_valid  out  1  `o_data` holds a valid symbol.
- o_data  out  2  coded symbol. Bit [1] = u^s1^s0 (g0=111). Bit [0] = u^s0 (g1=101).
- o_sof  out  1  qualifies the first data symbol of a frame.
- o_eof  out  1  qualifies the last tail symbol of a frame.
- o_busy  out  1  state is not IDLE.

## Operation
- Shift register {s1,s0}:
  - s1 is the previous input bit; s0 is the bit before that.
  - On each symbol generation with input u, the register updates to {u, s1}.
- Bit counter `cnt` has width $clog2(FRAME_LEN+1).
- Output register slot is free when `!o_valid || i_ready`.
- State machine:
  - IDLE: `o_ready`=0.
    - If `i_start`=1: clear s1, s0 and `cnt`, then go to DATA.
    - `i_valid` is ignored in IDLE.
  - DATA: `o_ready` = slot free.
    - On `i_valid && o_ready`: load `o_data` from u=`i_bit`, set `o_valid`=1, shift the register, increment `cnt`.
    - `o_sof`=1 when `cnt` was 0 at acceptance.
    - When the accepted bit is number FRAME_LEN, clear `cnt` and go to TAIL.
  - TAIL: `o_ready`=0.
    - Each cycle the slot is free, generate a symbol with u=0 and increment `cnt`.
    - On the 2nd tail symbol, set `o_eof`=1 and go to IDLE.
- `i_start` is ignored outside IDLE.
- Symbols are never dropped or duplicated:
  - While `o_valid && !i_ready`, `o_data`, `o_sof` and `o_eof` hold.
  - While `o_valid && !i_ready`, the shift register and `cnt` hold.
- `o_sof` and `o_eof` clear when their symbol is consumed and no new symbol is loaded.
- `o_valid` falls on consumption when no new symbol is generated in that cycle.

## Timing
- Reset values: `o_valid`=0, `o_data`=2'b00, `o_sof`=0, `o_eof`=0, `o_ready`=0, `o_busy`=0, state=IDLE, s1=s0=0, `cnt`=0.
- Latency: a bit accepted at edge N is presented on `o_data` after edge N (registered, 1 cycle).
- Throughput: with `i_ready` tied high, 1 symbol per cycle sustained. A frame occupies FRAME_LEN+2 symbol cycles.
- `o_busy` rises the cycle after `i_start` is sampled in IDLE.
  - `o_busy` falls the cycle after the final tail symbol is loaded.
  - The `o_eof` symbol may still be pending when `o_busy`=0.
- A new `i_start` is accepted once back in IDLE, even if the `o_eof` symbol has not yet been consumed. DATA loads wait for the slot to free.
- Back-to-back frames: `i_start` on the cycle after returning to IDLE gives a 1-cycle gap minimum.
- FRAME_LEN=1 goes DATA to TAIL after a single bit. That symbol carries `o_sof` only.
- Asserting `i_rst` mid-frame aborts immediately to reset values. No partial tail is emitted.
- `o_ready` is combinational from state, `o_valid` and `i_ready`. No combinational path exists from `i_valid` to `o_ready`.

## Test plan
- FRAME_LEN=4, `i_ready`=1, bits 1,0,1,1 -> symbols 11,10,00,01,01,11 on consecutive cycles. `o_sof` on the 1st symbol, `o_eof` on the 6th; final s1,s0=0,0.
- FRAME_LEN=4, all-zero input -> six 00 symbols. `o_busy` is high for 6 cycles.
- Same frame as the first test with `i_ready` toggled 1,0,0,1,... -> identical symbol sequence. `o_data` stable while stalled; `o_ready`=0 whenever `o_valid && !i_ready`.
- `i_valid` and `i_start` pulsed mid-frame; `i_valid` pulsed in IDLE -> no extra symbols; the frame completes unchanged.
- Reset asserted asynchronously after symbol 3 of a frame -> all outputs return to reset values without waiting for a clock edge. A following frame with bits 1,0,1,1 again yields 11,10,00,01,01,11.
- FRAME_LEN=1, bit 1 -> symbols 11 (`o_sof`), 10, 11 (`o_eof`).
